wtch_uart_report: RTL and testbench
===================================

Name: wtch_uart_report

Overview:
- Downstream consumer of the watch datapath outputs (msec/sec/min/hour).
- On a report request, snapshots the current time and serialises it as ASCII text "HH:MM:SS.CC" plus optional CR LF.
- Drives the byte-level UART transmitter through a start/busy/done handshake.
- Sits between the watch datapath and the UART TX in the dual-watch design.

Parameters:
- ADD_CRLF, 1, 1 appends 8'h0D 8'h0A after the time string (13 bytes); 0 sends 11 bytes.
- SEP_HMS, 8'h3A, separator byte between HH/MM and MM/SS (':').
- SEP_CS, 8'h2E, separator byte between SS and CC ('.').

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-high.
- req  input  1  report request, sampled only in IDLE.
- msec  input  7  centiseconds 0..99.
- sec  input  6  seconds 0..59.
- min  input  6  minutes 0..59.
- hour  input  5  hours 0..23.
- tx_busy  input  1  UART TX busy; high while a byte is in flight.
- tx_done  input  1  one-cycle pulse from UART TX when a byte completes.
- tx_start  output  1  one-cycle pulse launching tx_data.
- tx_data  output  8  byte to transmit.
- busy  output  1  high from request acceptance until frame completion.
- done  output  1  one-cycle pulse after the last byte's tx_done.

Behaviour:
- Reset values: state=IDLE, tx_start=0, tx_data=8'h00, busy=0, done=0, byte index=0, snapshot registers=0.
  - Asynchronous assertion; any frame in progress is abandoned with no further tx_start.
- FSM states are IDLE, SEND and WAIT.
- IDLE:
  - busy=0.
  - req=1 at edge k: latch hour/min/sec/msec into snapshot registers, index=0, busy=1 from edge k, go to SEND.
- SEND:
  - If tx_busy=0 at an edge: register tx_start=1 for exactly one cycle, register tx_data=byte(index), go to WAIT.
  - If tx_busy=1: stay in SEND with no pulse (stall indefinitely).
  - Minimum latency: req at edge k gives tx_start high in the cycle after edge k+1.
- WAIT:
  - tx_data is held stable.
  - tx_done=1 on a non-last byte: index+1, go to SEND.
  - tx_done=1 on the last byte: done pulse for one cycle, busy=0, go to IDLE.
  - tx_done when not in WAIT is ignored.
- Byte order, index 0..12:
  - H tens, H ones, SEP_HMS
  - M tens, M ones, SEP_HMS
  - S tens, S ones, SEP_CS
  - C tens, C ones
  - 8'h0D, 8'h0A (only when ADD_CRLF=1)
  - Last index is 12 when ADD_CRLF=1, 10 otherwise.
- Digit conversion:
  - Field value v is zero-extended to 7 bits. tens = v/10, ones = v - 10*tens, both for v in 0..99.
  - Values above 99 saturate to "99" (possible only on msec).
  - ASCII = 8'h30 + digit.
  - Implement by comparison/subtraction; no divider IP.
- Snapshot:
  - Output bytes derive only from the latched snapshot.
  - Input changes during a frame do not affect the frame (no tearing across the hour/min/sec boundary).
- Simultaneous events:
  - req while busy=1 is ignored; it is not queued.
  - req in the same cycle as done is ignored; a new frame needs req with busy=0.
  - tx_busy and tx_done may both be high in WAIT; tx_done takes precedence.

Test Plan:
- Reset, then hour=12 min=0 sec=0 msec=0, req pulse, TX model with 10-cycle byte time (ADD_CRLF=1) -> bytes 31 32 3A 30 30 3A 30 30 2E 30 30 0D 0A; 13 tx_start pulses; one done pulse; busy high throughout.
- hour=23 min=59 sec=59 msec=99, req; inputs change to 0:0:0.00 one cycle later -> "23:59:59.99\r\n" (snapshot held).
- msec=120, ADD_CRLF=0 -> 11 bytes ending 39 39; no 0D/0A; done after 11th tx_done.
- tx_busy forced high for 50 cycles after req -> no tx_start while high; first tx_start exactly one cycle after tx_busy falls; req pulses mid-frame produce no second frame.
- Assert rst after the 5th byte's tx_start -> tx_start=0, busy=0, tx_data=00 immediately; next req restarts at index 0 with a fresh snapshot.
- Check tx_start never held more than 1 cycle, and tx_data constant from tx_start until the matching tx_done, across all above.

Source files
------------

// File: rtl/wtch_uart_report.sv
// Snapshots the watch time on request and streams "HH:MM:SS.CC" (+ optional CR LF)
// to a byte-wide UART transmitter over a start/busy/done handshake.
module wtch_uart_report #(
  parameter bit         ADD_CRLF = 1'b1,
  parameter logic [7:0] SEP_HMS  = 8'h3A,
  parameter logic [7:0] SEP_CS   = 8'h2E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = ADD_CRLF ? 4'd12 : 4'd10;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic       tx_start_nxt, busy_nxt, done_nxt, snap_load;
  logic [7:0] tx_data_nxt, byte_cur;
  logic [6:0] snap_msec;
  logic [5:0] snap_sec, snap_min;
  logic [4:0] snap_hour;
  logic [15:0] asc_h, asc_m, asc_s, asc_c;

  // Two ASCII digits {tens, ones} of v; anything above 99 saturates to "99".
  // Tens are peeled off by repeated compare/subtract so no divider is needed.
  function automatic logic [15:0] to_ascii2(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = (v > 7'd99) ? 7'd99 : v;
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {8'h30 + {4'h0, t}, 8'h30 + {1'b0, r}};
  endfunction

  assign asc_h = to_ascii2({2'b00, snap_hour});
  assign asc_m = to_ascii2({1'b0, snap_min});
  assign asc_s = to_ascii2({1'b0, snap_sec});
  assign asc_c = to_ascii2(snap_msec);

  always_comb begin
    byte_cur = 8'h00;
    case (idx)
      4'd0:    byte_cur = asc_h[15:8];
      4'd1:    byte_cur = asc_h[7:0];
      4'd2:    byte_cur = SEP_HMS;
      4'd3:    byte_cur = asc_m[15:8];
      4'd4:    byte_cur = asc_m[7:0];
      4'd5:    byte_cur = SEP_HMS;
      4'd6:    byte_cur = asc_s[15:8];
      4'd7:    byte_cur = asc_s[7:0];
      4'd8:    byte_cur = SEP_CS;
      4'd9:    byte_cur = asc_c[15:8];
      4'd10:   byte_cur = asc_c[7:0];
      4'd11:   byte_cur = 8'h0D;
      4'd12:   byte_cur = 8'h0A;
      default: byte_cur = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    snap_load    = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        // A request coinciding with the completion pulse is dropped, not queued.
        if (req && !done) begin
          snap_load = 1'b1;
          idx_nxt   = 4'd0;
          busy_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = byte_cur;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      snap_msec <= 7'd0;
      snap_sec  <= 6'd0;
      snap_min  <= 6'd0;
      snap_hour <= 5'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      if (snap_load) begin
        snap_msec <= msec;
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
      end
    end
  end

endmodule

// File: tb/tb_wtch_uart_report.sv
// Directed bench for wtch_uart_report: a 10-cycle UART TX model drives the main
// instance (CR LF on); a second instance without CR LF is handshaken by hand.
module tb_wtch_uart_report;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [6:0] msec = 7'd0;
  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic [4:0] hour = 5'd0;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic       tx_start, busy, done;
  logic [7:0] tx_data;

  logic       req2 = 1'b0;
  logic       tx_busy2 = 1'b0;
  logic       tx_done2 = 1'b0;
  logic       tx_start2, busy2, done2;
  logic [7:0] tx_data2;

  logic       busy_m = 1'b0;
  logic       force_busy = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] cur = 8'h00;
  logic [7:0] got[$];
  logic [7:0] exp13[13];
  logic [7:0] exp11[11];
  int         cnt = 0;
  int         starts = 0;
  int         dones = 0;
  int         total = 0;
  int         bad = 0;

  assign tx_busy = busy_m | force_busy;

  always #5 clk = ~clk;

  wtch_uart_report #(.ADD_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .done(done)
  );

  wtch_uart_report #(.ADD_CRLF(1'b0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .tx_busy(tx_busy2), .tx_done(tx_done2), .tx_start(tx_start2), .tx_data(tx_data2),
    .busy(busy2), .done(done2)
  );

  // TX model and protocol monitor, evaluated 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (rst) begin
      busy_m = 1'b0;
      cnt = 0;
      prev_start = 1'b0;
    end else begin
      total++;
      if (prev_start && tx_start) begin
        bad++;
        $display("FAIL start_width: tx_start=1 on two consecutive cycles, required single-cycle pulse");
      end
      prev_start = tx_start;
      if (tx_start) begin
        got.push_back(tx_data);
        cur = tx_data;
        busy_m = 1'b1;
        cnt = 10;
        starts++;
      end else if (busy_m) begin
        total++;
        if (tx_data !== cur) begin
          bad++;
          $display("FAIL data_stable: tx_data=%h required %h", tx_data, cur);
        end
        cnt--;
        if (cnt == 0) begin
          busy_m = 1'b0;
          tx_done = 1'b1;
        end
      end
      if (done) dones++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_frame(output bit to, output int blow);
    to = 1'b1;
    blow = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
      if (!busy) blow++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_start, tx_data, busy, done} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs: start=%b data=%h busy=%b done=%b required all 0", tx_start, tx_data, busy, done);
    end
    total++;
    if ({tx_start2, tx_data2, busy2, done2} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs2: start=%b data=%h busy=%b done=%b required all 0", tx_start2, tx_data2, busy2, done2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    int blow, s0, d0;
    hour = 5'd12; min = 6'd0; sec = 6'd0; msec = 7'd0;
    exp13 = '{8'h31, 8'h32, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};
    got.delete();
    s0 = starts; d0 = dones;
    pulse_req();
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL first_latency: tx_start=%b busy=%b required 1 1", tx_start, busy);
    end
    wait_frame(to, blow);
    total++;
    if (to || blow != 0) begin
      bad++;
      $display("FAIL basic_frame: timeout=%0d busy_low_cycles=%0d required 0 0", to, blow);
    end
    total++;
    if (got.size() != 13) begin
      bad++;
      $display("FAIL basic_count: bytes=%0d required 13", got.size());
    end
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp13[i]) begin
        bad++;
        $display("FAIL basic_byte%0d: got %h required %h", i, got[i], exp13[i]);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (starts - s0 != 13 || dones - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulses: starts=%0d dones=%0d busy=%b required 13 1 0", starts - s0, dones - d0, busy);
    end
  endtask

  task automatic test_snapshot();
    bit to;
    int blow;
    hour = 5'd23; min = 6'd59; sec = 6'd59; msec = 7'd99;
    exp13 = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
    got.delete();
    pulse_req();
    hour = 5'd0; min = 6'd0; sec = 6'd0; msec = 7'd0;
    wait_frame(to, blow);
    total++;
    if (to || blow != 0 || got.size() != 13) begin
      bad++;
      $display("FAIL snap_frame: timeout=%0d busy_low=%0d bytes=%0d required 0 0 13", to, blow, got.size());
    end
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp13[i]) begin
        bad++;
        $display("FAIL snap_byte%0d: got %h required %h", i, got[i], exp13[i]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stall();
    bit to;
    int blow, s0;
    hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd4;
    exp13 = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h2E, 8'h30, 8'h34, 8'h0D, 8'h0A};
    got.delete();
    s0 = starts;
    force_busy = 1'b1;
    pulse_req();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req = (i == 20 || i == 30);
    end
    req = 1'b0;
    total++;
    if (starts != s0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold: starts=%0d busy=%b required 0 1", starts - s0, busy);
    end
    force_busy = 1'b0;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: tx_start=%b required 1", tx_start);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req = (i == 40 || i == 90);
      if (i == 100) break;
    end
    req = 1'b0;
    wait_frame(to, blow);
    total++;
    if (to || blow != 0 || got.size() != 13) begin
      bad++;
      $display("FAIL stall_frame: timeout=%0d busy_low=%0d bytes=%0d required 0 0 13", to, blow, got.size());
    end
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp13[i]) begin
        bad++;
        $display("FAIL stall_byte%0d: got %h required %h", i, got[i], exp13[i]);
      end
    end
    repeat (30) @(negedge clk);
    total++;
    if (starts - s0 != 13 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_second: starts=%0d busy=%b required 13 0", starts - s0, busy);
    end
  endtask

  task automatic test_abort();
    bit to, ok;
    int blow, s0;
    hour = 5'd5; min = 6'd6; sec = 6'd7; msec = 7'd8;
    s0 = starts;
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (starts - s0 == 5) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || tx_start !== 1'b1) begin
      bad++;
      $display("FAIL abort_reach5: reached=%0d tx_start=%b required 1 1", ok, tx_start);
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL abort_async: start=%b busy=%b data=%h required 0 0 00", tx_start, busy, tx_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    repeat (20) @(negedge clk);
    total++;
    if (starts != s0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: starts=%0d busy=%b required 0 0", starts - s0, busy);
    end
    hour = 5'd10; min = 6'd20; sec = 6'd30; msec = 7'd40;
    exp13 = '{8'h31, 8'h30, 8'h3A, 8'h32, 8'h30, 8'h3A, 8'h33, 8'h30, 8'h2E, 8'h34, 8'h30, 8'h0D, 8'h0A};
    got.delete();
    pulse_req();
    wait_frame(to, blow);
    total++;
    if (to || blow != 0 || got.size() != 13) begin
      bad++;
      $display("FAIL abort_restart: timeout=%0d busy_low=%0d bytes=%0d required 0 0 13", to, blow, got.size());
    end
    for (int i = 0; i < 13 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp13[i]) begin
        bad++;
        $display("FAIL restart_byte%0d: got %h required %h", i, got[i], exp13[i]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_no_crlf();
    bit ok;
    logic [7:0] got2[$];
    hour = 5'd7; min = 6'd8; sec = 6'd9; msec = 7'd120;
    exp11 = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h39, 8'h2E, 8'h39, 8'h39};
    @(negedge clk) req2 = 1'b1;
    @(negedge clk) req2 = 1'b0;
    for (int b = 0; b < 11; b++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (tx_start2) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL nocrlf_start%0d: no tx_start within 50 cycles, required one", b);
        break;
      end
      got2.push_back(tx_data2);
      repeat (3) @(negedge clk);
      tx_done2 = 1'b1;
      @(negedge clk);
      tx_done2 = 1'b0;
    end
    total++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL nocrlf_done: done=%b busy=%b required 1 0", done2, busy2);
    end
    for (int i = 0; i < 11 && i < got2.size(); i++) begin
      total++;
      if (got2[i] !== exp11[i]) begin
        bad++;
        $display("FAIL nocrlf_byte%0d: got %h required %h", i, got2[i], exp11[i]);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start2 || done2) ok = 1'b1;
    end
    total++;
    if (ok || got2.size() != 11) begin
      bad++;
      $display("FAIL nocrlf_end: extra_activity=%0d bytes=%0d required 0 11", ok, got2.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_stall();
    test_abort();
    test_no_crlf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
